// File: rtl/field_step_engine.sv
// field_step_engine: computes one Life generation by streaming rows through a 3-row window.
// Ports:
//    i_clk, i_rst_n  clock and asynchronous active-low reset
//    i_start         one-cycle request for a generation, taken only when idle
//    o_rd_en         row read strobe; i_rd_data returns that row one cycle later
//    o_rd_addr       row index to read (0 when o_rd_en is low)
//    i_rd_data       current-generation row, bit c = column c
//    o_wr_en         next-generation row write strobe
//    o_wr_addr       row index being written (0 when o_wr_en is low)
//    o_wr_data       next-generation row
//    o_busy          generation in progress
//    o_done          one-cycle pulse once the last row has been written
module field_step_engine #(
   parameter int FIELD_W = 64,
   parameter int FIELD_H = 48,
   parameter int WRAP    = 1,
   parameter int ADDR_W  = $clog2(FIELD_H)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   output logic               o_rd_en,
   output logic [ADDR_W-1:0]  o_rd_addr,
   input  logic [FIELD_W-1:0] i_rd_data,
   output logic               o_wr_en,
   output logic [ADDR_W-1:0]  o_wr_addr,
   output logic [FIELD_W-1:0] o_wr_data,
   output logic               o_busy,
   output logic               o_done
);
   localparam int CW = $clog2(FIELD_H + 6);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [CW-1:0] C_RD_END = CW'(FIELD_H + 2);
   localparam logic [CW-1:0] C_SH_END = CW'(FIELD_H + 3);
   localparam logic [CW-1:0] C_DR_END = CW'(FIELD_H + 4);

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cyc_q, cyc_d;
   logic [CW-1:0]      slot;
   logic               rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
   logic               rd_pend_q, rd_pend_d;
   logic               shift;
   logic [FIELD_W-1:0] row_in;
   logic [FIELD_W-1:0] top_q, top_d, mid_q, mid_d, bot_q, bot_d;
   logic [FIELD_W-1:0] nxt;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [FIELD_W-1:0] wr_data_q, wr_data_d;

   function automatic logic next_cell_state(input logic [7:0] nbr, input logic st);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, nbr[i]};
      return (cnt == 4'd3) || (st && cnt == 4'd2);
   endfunction

   // cyc_q numbers the cycles of a generation: 1 is the first read, FIELD_H+5 the done cycle.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      case (state_q)
         S_IDLE:  if (i_start) begin
            state_d = S_READ;
            cyc_d   = CW'(1);
         end
         S_READ: begin
            cyc_d   = cyc_q + CW'(1);
            state_d = (cyc_q == C_RD_END) ? S_DRAIN : S_READ;
         end
         S_DRAIN: begin
            cyc_d   = cyc_q + CW'(1);
            state_d = (cyc_q == C_DR_END) ? S_DONE : S_DRAIN;
         end
         default: begin
            state_d = S_IDLE;
            cyc_d   = '0;
         end
      endcase
      // Slot k is issued in cycle k+1; slots 0 and FIELD_H+1 are the wrap-around halo rows.
      slot      = cyc_d - CW'(1);
      rd_en_d   = (state_d == S_READ) &&
                  ((WRAP != 0) || (slot != '0 && slot != CW'(FIELD_H + 1)));
      rd_addr_d = !rd_en_d ? '0 :
                  (slot == '0) ? ADDR_W'(FIELD_H - 1) :
                  (slot == CW'(FIELD_H + 1)) ? '0 : ADDR_W'(slot - CW'(1));
      rd_pend_d = rd_en_q;
      // Halo slots that were not read feed a dead row instead of whatever is on the bus.
      row_in    = rd_pend_q ? i_rd_data : '0;
      shift     = (state_q != S_IDLE) && (cyc_q >= CW'(2)) && (cyc_q <= C_SH_END);
      top_d     = shift ? mid_q : top_q;
      mid_d     = shift ? bot_q : mid_q;
      bot_d     = shift ? row_in : bot_q;
   end

   // Evaluate on the window as it will be after this cycle's shift, so the row is
   // registered in the same cycle its last input row arrives.
   for (genvar c = 0; c < FIELD_W; c++) begin : g_cell
      localparam int   L  = (c == 0) ? FIELD_W - 1 : c - 1;
      localparam int   R  = (c == FIELD_W - 1) ? 0 : c + 1;
      localparam logic LV = (WRAP != 0) || (c != 0);
      localparam logic RV = (WRAP != 0) || (c != FIELD_W - 1);
      assign nxt[c] = next_cell_state({bot_d[R] & RV, bot_d[c], bot_d[L] & LV,
                                       mid_d[R] & RV, mid_d[L] & LV,
                                       top_d[R] & RV, top_d[c], top_d[L] & LV}, mid_d[c]);
   end

   // The first full window exists after the third data arrival (cycle 4), giving row 0 in cycle 5.
   always_comb begin
      wr_en_d   = shift && (cyc_q >= CW'(4));
      wr_addr_d = wr_en_d ? ADDR_W'(cyc_q - CW'(4)) : '0;
      wr_data_d = wr_en_d ? nxt : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         cyc_q     <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_pend_q <= 1'b0;
         top_q     <= '0;
         mid_q     <= '0;
         bot_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         rd_pend_q <= rd_pend_d;
         top_q     <= top_d;
         mid_q     <= mid_d;
         bot_q     <= bot_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign o_rd_en   = rd_en_q;
   assign o_rd_addr = rd_addr_q;
   assign o_wr_en   = wr_en_q;
   assign o_wr_addr = wr_addr_q;
   assign o_wr_data = wr_data_q;
   assign o_busy    = (state_q == S_READ) || (state_q == S_DRAIN);
   assign o_done    = (state_q == S_DONE);
endmodule

// File: tb/tb_field_step_engine.sv
// tb_field_step_engine: directed checks of field_step_engine with toroidal and bounded edges.
module tb_field_step_engine;
   localparam int W = 8;
   localparam int H = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   always #5 clk = ~clk;

   logic         rd_en1, rd_en0, wr_en1, wr_en0, busy1, busy0, done1, done0;
   logic [2:0]   rd_addr1, rd_addr0, wr_addr1, wr_addr0;
   logic [W-1:0] rd_data1, rd_data0, wr_data1, wr_data0;
   logic [W-1:0] mem_a [H];
   logic [W-1:0] wb1 [H];
   logic [W-1:0] wb0 [H];
   int tests = 0;
   int fails = 0;

   field_step_engine #(.FIELD_W(W), .FIELD_H(H), .WRAP(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .o_rd_en(rd_en1), .o_rd_addr(rd_addr1), .i_rd_data(rd_data1),
      .o_wr_en(wr_en1), .o_wr_addr(wr_addr1), .o_wr_data(wr_data1),
      .o_busy(busy1), .o_done(done1));

   field_step_engine #(.FIELD_W(W), .FIELD_H(H), .WRAP(0)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .o_rd_en(rd_en0), .o_rd_addr(rd_addr0), .i_rd_data(rd_data0),
      .o_wr_en(wr_en0), .o_wr_addr(wr_addr0), .o_wr_data(wr_data0),
      .o_busy(busy0), .o_done(done0));

   // Shared read buffer, one write buffer per engine; unread cycles return all-ones.
   always @(posedge clk) begin
      rd_data1 <= rd_en1 ? mem_a[rd_addr1] : 8'hFF;
      rd_data0 <= rd_en0 ? mem_a[rd_addr0] : 8'hFF;
      if (wr_en1) wb1[wr_addr1] = wr_data1;
      if (wr_en0) wb0[wr_addr0] = wr_data0;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [47:0] f);
      for (int r = 0; r < H; r++) begin
         mem_a[r] = f[r*8 +: 8];
         wb1[r] = 8'h5A;
         wb0[r] = 8'h5A;
      end
   endtask

   task automatic swap();
      for (int r = 0; r < H; r++) begin
         mem_a[r] = wb1[r];
         wb1[r] = 8'h5A;
         wb0[r] = 8'h5A;
      end
   endtask

   // Starts one generation and checks every cycle 1..H+5; extra adds ignored starts in cycles 3 and 10.
   task automatic gen(input logic [47:0] e1, input logic [47:0] e0, input bit c1, input bit c0,
                      input bit extra);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 1; n <= H + 5; n++) begin
         logic ew, er1, er0;
         if (n > 1) @(negedge clk);
         ew  = (n >= 5) && (n <= H + 4);
         er1 = (n <= H + 2);
         er0 = (n >= 2) && (n <= H + 1);
         chk($sformatf("c%0d wr_en", n), wr_en1, ew);
         chk($sformatf("c%0d wr_addr", n), wr_addr1, ew ? n - 5 : 0);
         chk($sformatf("c%0d busy", n), busy1, n <= H + 4);
         chk($sformatf("c%0d done", n), done1, n == H + 5);
         chk($sformatf("c%0d rd_en", n), rd_en1, er1);
         chk($sformatf("c%0d rd_addr", n), rd_addr1,
             n == 1 ? H - 1 : (n == H + 2 || !er1) ? 0 : n - 2);
         chk($sformatf("c%0d wr_en0", n), wr_en0, ew);
         chk($sformatf("c%0d done0", n), done0, n == H + 5);
         chk($sformatf("c%0d rd_en0", n), rd_en0, er0);
         chk($sformatf("c%0d rd_addr0", n), rd_addr0, er0 ? n - 2 : 0);
         start = extra && (n == 3 || n == 10);
      end
      for (int r = 0; r < H; r++) begin
         if (c1) chk($sformatf("row%0d wrap1", r), wb1[r], e1[r*8 +: 8]);
         if (c0) chk($sformatf("row%0d wrap0", r), wb0[r], e0[r*8 +: 8]);
      end
   endtask

   // Fields packed row 5 .. row 0, row 0 in the low byte.
   localparam logic [47:0] BLINK   = 48'h000808080000;
   localparam logic [47:0] BLINK_N = 48'h00001C000000;
   localparam logic [47:0] BLOCK   = 48'h000000060600;
   localparam logic [47:0] CORNER  = 48'h010000000081;
   localparam logic [47:0] CORN_W1 = 48'h810000000081;
   localparam logic [47:0] GLIDER  = 48'h000000070402;
   // 24 generations move the glider 6 rows down (back to row 0) and 6 columns right, mod 8.
   localparam logic [47:0] GLID_24 = 48'h000000C10180;

   initial begin
      repeat (3) @(negedge clk);
      chk("rst rd_en", rd_en1, 0);
      chk("rst rd_addr", rd_addr1, 0);
      chk("rst wr_en", wr_en1, 0);
      chk("rst wr_addr", wr_addr1, 0);
      chk("rst wr_data", wr_data1, 0);
      chk("rst busy", busy1, 0);
      chk("rst done", done1, 0);
      chk("rst rd_en0", rd_en0, 0);
      rst_n = 1'b1;

      load(BLINK);
      gen(BLINK_N, BLINK_N, 1, 1, 0);

      load(BLOCK);
      gen(BLOCK, BLOCK, 1, 1, 0);
      for (int g = 0; g < 9; g++) begin
         swap();
         gen(BLOCK, BLOCK, 1, 1, 0);
      end

      load(CORNER);
      gen(CORN_W1, 48'h0, 1, 1, 0);

      load(GLIDER);
      for (int g = 0; g < 23; g++) begin
         gen(48'h0, 48'h0, 0, 0, 0);
         swap();
      end
      gen(GLID_24, 48'h0, 1, 0, 0);

      load(BLINK);
      gen(BLINK_N, BLINK_N, 1, 1, 1);
      gen(BLINK_N, BLINK_N, 1, 1, 0);

      load(BLINK);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre-rst wr_en", wr_en1, 1);
      rst_n = 1'b0;
      #1;
      chk("arst rd_en", rd_en1, 0);
      chk("arst rd_addr", rd_addr1, 0);
      chk("arst wr_en", wr_en1, 0);
      chk("arst wr_addr", wr_addr1, 0);
      chk("arst wr_data", wr_data1, 0);
      chk("arst busy", busy1, 0);
      chk("arst done", done1, 0);
      chk("arst busy0", busy0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("arst row0", wb1[0], 8'h00);
      chk("arst row1", wb1[1], 8'h00);
      for (int r = 2; r < H; r++) chk($sformatf("arst row%0d untouched", r), wb1[r], 8'h5A);
      load(BLINK);
      gen(BLINK_N, BLINK_N, 1, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
